fpdiv_ctrl: RTL and testbench

FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

---
 rtl/fpdiv_ctrl.sv | 130 +++++++++++++
 tb/tb_fpdiv_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_ctrl.sv
// Sequencing FSM for a Goldschmidt divider: steers the shared multiplier's operand
// muxes and the rega/regb/regc load enables, then pulses done when regb holds the quotient.
module fpdiv_ctrl #(
    parameter int unsigned ITERS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       flush,
    output logic [1:0] sel_muxa,
    output logic [1:0] sel_muxb,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       busy,
    output logic       done,
    output logic [2:0] iter
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_Q0   = 3'd1;
    localparam logic [2:0] S_D0   = 3'd2;
    localparam logic [2:0] S_QN   = 3'd3;
    localparam logic [2:0] S_DN   = 3'd4;
    localparam logic [2:0] S_RND  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam bit         SINGLE    = (ITERS == 1);
    localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] iter_q, iter_d;

    // The final iteration stops after its Q step; D is only refined when another Q follows.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_Q0;
                        iter_d  = '0;
                    end
                end
                S_Q0:   state_d = SINGLE ? S_RND : S_D0;
                S_D0: begin
                    state_d = S_QN;
                    iter_d  = iter_q + 3'd1;
                end
                S_QN:   state_d = (iter_q == LAST_ITER) ? S_RND : S_DN;
                S_DN: begin
                    state_d = S_QN;
                    iter_d  = iter_q + 3'd1;
                end
                S_RND:  state_d = S_DONE;
                S_DONE: begin
                    if (start) begin
                        state_d = S_Q0;
                        iter_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        sel_muxa = 2'd0;
        sel_muxb = 2'd0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_Q0: begin
                sel_muxa = 2'd2;
                sel_muxb = 2'd1;
                loadb    = 1'b1;
                busy     = 1'b1;
            end
            S_D0: begin
                sel_muxa = 2'd2;
                sel_muxb = 2'd0;
                loada    = 1'b1;
                loadc    = 1'b1;
                busy     = 1'b1;
            end
            S_QN: begin
                sel_muxa = 2'd0;
                sel_muxb = 2'd2;
                loadb    = 1'b1;
                busy     = 1'b1;
            end
            S_DN: begin
                sel_muxa = 2'd0;
                sel_muxb = 2'd3;
                loada    = 1'b1;
                loadc    = 1'b1;
                busy     = 1'b1;
            end
            S_RND: begin
                sel_muxa = 2'd1;
                sel_muxb = 2'd2;
                loadc    = 1'b1;
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign iter = iter_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed bench for fpdiv_ctrl; three instances cover ITERS = 3, 1 and 2 from shared stimulus.
module tb_fpdiv_ctrl;

    logic clk;
    logic reset;
    logic start;
    logic flush;

    logic [1:0] sa3, sb3, sa1, sb1, sa2, sb2;
    logic       la3, lb3, lc3, bz3, dn3;
    logic       la1, lb1, lc1, bz1, dn1;
    logic       la2, lb2, lc2, bz2, dn2;
    logic [2:0] it3, it1, it2;

    int total;
    int bad;

    // Row layout: {sel_muxa, sel_muxb, loada, loadb, loadc, busy, done, iter}
    logic [11:0] obs3, obs1, obs2;
    assign obs3 = {sa3, sb3, la3, lb3, lc3, bz3, dn3, it3};
    assign obs1 = {sa1, sb1, la1, lb1, lc1, bz1, dn1, it1};
    assign obs2 = {sa2, sb2, la2, lb2, lc2, bz2, dn2, it2};

    localparam logic [11:0] EXP3 [8] = '{
        12'b10_01_010_1_0_000,
        12'b10_00_101_1_0_000,
        12'b00_10_010_1_0_001,
        12'b00_11_101_1_0_001,
        12'b00_10_010_1_0_010,
        12'b01_10_001_1_0_010,
        12'b00_00_000_0_1_010,
        12'b00_00_000_0_0_010
    };

    localparam logic [11:0] EXP1 [4] = '{
        12'b10_01_010_1_0_000,
        12'b01_10_001_1_0_000,
        12'b00_00_000_0_1_000,
        12'b00_00_000_0_0_000
    };

    localparam logic [11:0] EXP2 [5] = '{
        12'b10_01_010_1_0_000,
        12'b10_00_101_1_0_000,
        12'b00_10_010_1_0_001,
        12'b01_10_001_1_0_001,
        12'b00_00_000_0_1_001
    };

    fpdiv_ctrl #(.ITERS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .sel_muxa(sa3), .sel_muxb(sb3), .loada(la3), .loadb(lb3), .loadc(lc3),
        .busy(bz3), .done(dn3), .iter(it3)
    );

    fpdiv_ctrl #(.ITERS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .sel_muxa(sa1), .sel_muxb(sb1), .loada(la1), .loadb(lb1), .loadc(lc1),
        .busy(bz1), .done(dn1), .iter(it1)
    );

    fpdiv_ctrl #(.ITERS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .sel_muxa(sa2), .sel_muxb(sb2), .loada(la2), .loadb(lb2), .loadc(lc2),
        .busy(bz2), .done(dn2), .iter(it2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns every instance to IDLE with a one-cycle flush.
    task automatic go_idle();
        start = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
    endtask

    // Pulses start across one edge; on return the bench is inside cycle 1.
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (obs3 !== 12'd0) begin
            bad++;
            $display("FAIL reset_i3 got=%b exp=%b", obs3, 12'd0);
        end
        total++;
        if (obs1 !== 12'd0) begin
            bad++;
            $display("FAIL reset_i1 got=%b exp=%b", obs1, 12'd0);
        end
        total++;
        if (obs2 !== 12'd0) begin
            bad++;
            $display("FAIL reset_i2 got=%b exp=%b", obs2, 12'd0);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_iters3();
        go_idle();
        pulse_start();
        for (int c = 0; c < 8; c++) begin
            total++;
            if (obs3 !== EXP3[c]) begin
                bad++;
                $display("FAIL iters3_seq cyc=%0d got=%b exp=%b", c + 1, obs3, EXP3[c]);
            end
            step();
        end
    endtask

    task automatic test_iters1();
        go_idle();
        pulse_start();
        for (int c = 0; c < 4; c++) begin
            total++;
            if (obs1 !== EXP1[c]) begin
                bad++;
                $display("FAIL iters1_seq cyc=%0d got=%b exp=%b", c + 1, obs1, EXP1[c]);
            end
            total++;
            if (la1 !== 1'b0) begin
                bad++;
                $display("FAIL iters1_no_dstep cyc=%0d got=%b exp=0", c + 1, la1);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        go_idle();
        start = 1'b1;
        step();
        for (int c = 0; c < 11; c++) begin
            total++;
            if (obs2 !== EXP2[c % 5]) begin
                bad++;
                $display("FAIL b2b_seq cyc=%0d got=%b exp=%b", c + 1, obs2, EXP2[c % 5]);
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_flush();
        int dones;
        go_idle();
        pulse_start();
        step();
        step();
        step();
        total++;
        if (obs3 !== EXP3[3]) begin
            bad++;
            $display("FAIL flush_pre_dn got=%b exp=%b", obs3, EXP3[3]);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if (obs3 !== 12'b00_00_000_0_0_001) begin
            bad++;
            $display("FAIL flush_idle got=%b exp=%b", obs3, 12'b00_00_000_0_0_001);
        end
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (dn3 === 1'b1 || bz3 !== 1'b0) dones++;
            step();
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL flush_no_done got=%0d exp=0", dones);
        end
        pulse_start();
        for (int c = 0; c < 8; c++) begin
            total++;
            if (obs3 !== EXP3[c]) begin
                bad++;
                $display("FAIL flush_rerun cyc=%0d got=%b exp=%b", c + 1, obs3, EXP3[c]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        int activity;
        go_idle();
        pulse_start();
        step();
        step();
        total++;
        if (obs3 !== EXP3[2]) begin
            bad++;
            $display("FAIL rstmid_pre_qn got=%b exp=%b", obs3, EXP3[2]);
        end
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (obs3 !== 12'd0) begin
            bad++;
            $display("FAIL rstmid_async got=%b exp=%b", obs3, 12'd0);
        end
        step();
        reset = 1'b1;
        activity = 0;
        for (int c = 0; c < 10; c++) begin
            if (dn3 !== 1'b0 || bz3 !== 1'b0) activity++;
            step();
        end
        total++;
        if (activity !== 0) begin
            bad++;
            $display("FAIL rstmid_no_done got=%0d exp=0", activity);
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        go_idle();
        pulse_start();
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            start = (c >= 1 && c <= 4);
            if (c < 8) begin
                total++;
                if (obs3 !== EXP3[c]) begin
                    bad++;
                    $display("FAIL ignstart_seq cyc=%0d got=%b exp=%b", c + 1, obs3, EXP3[c]);
                end
            end
            if (dn3 === 1'b1) dones++;
            step();
        end
        start = 1'b0;
        total++;
        if (dones !== 1) begin
            bad++;
            $display("FAIL ignstart_done_count got=%0d exp=1", dones);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_iters3();
        test_iters1();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
